// File: rtl/truth_table_checker.sv
// Clocked response monitor: sweeps a small combinational block through every input vector
// and compares each settled response against a latched expected truth table.
module truth_table_checker #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_valid
);

    localparam int unsigned NVEC = 2**N_IN;
    localparam int unsigned SW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);
    localparam logic [N_IN:0] ERR_MAX     = (N_IN + 1)'(NVEC);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              r_state;
    logic [NVEC-1:0]     r_table;
    logic [N_IN-1:0]     r_vec;
    logic [SW-1:0]       r_settle;
    logic [N_IN:0]       r_err;
    logic [N_IN-1:0]     r_ff;
    logic                r_ffv;
    logic                r_pass;

    state_e              w_state_next;
    logic [NVEC-1:0]     w_table_next;
    logic [N_IN-1:0]     w_vec_next;
    logic [SW-1:0]       w_settle_next;
    logic [N_IN:0]       w_err_next;
    logic [N_IN-1:0]     w_ff_next;
    logic                w_ffv_next;
    logic                w_pass_next;

    logic                w_sample;
    logic                w_last;
    logic                w_mismatch;
    logic                w_accept;

    assign w_sample   = (r_state == StRun) && (r_settle == SETTLE_LAST);
    assign w_last     = (r_vec == {N_IN{1'b1}});
    assign w_mismatch = w_sample && (dut_y != r_table[r_vec]);
    // start during RUN is dropped, not queued
    assign w_accept   = start && (r_state != StRun);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_sample && w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = start ? StRun : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        w_table_next  = r_table;
        w_vec_next    = r_vec;
        w_settle_next = r_settle;
        w_err_next    = r_err;
        w_ff_next     = r_ff;
        w_ffv_next    = r_ffv;
        w_pass_next   = r_pass;

        if (w_accept) begin
            w_table_next  = expected;
            w_vec_next    = '0;
            w_settle_next = '0;
            w_err_next    = '0;
            w_ff_next     = '0;
            w_ffv_next    = 1'b0;
            w_pass_next   = 1'b0;
        end else if (r_state == StRun) begin
            if (w_sample) begin
                w_settle_next = '0;
                // Last vector rolls the counter back to 0 exactly as the sweep ends
                w_vec_next    = r_vec + 1'b1;
                if (w_mismatch) begin
                    if (r_err != ERR_MAX) begin
                        w_err_next = r_err + 1'b1;
                    end
                    if (!r_ffv) begin
                        w_ff_next  = r_vec;
                        w_ffv_next = 1'b1;
                    end
                end
                if (w_last) begin
                    w_pass_next = (w_err_next == '0);
                end
            end else begin
                w_settle_next = r_settle + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_table  <= '0;
            r_vec    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_ff     <= '0;
            r_ffv    <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_table  <= w_table_next;
            r_vec    <= w_vec_next;
            r_settle <= w_settle_next;
            r_err    <= w_err_next;
            r_ff     <= w_ff_next;
            r_ffv    <= w_ffv_next;
            r_pass   <= w_pass_next;
        end
    end

    assign dut_in           = r_vec;
    assign busy             = (r_state == StRun);
    assign done             = (r_state == StDone);
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail       = r_ff;
    assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=0) sweep a table-driven
// model DUT; results are predicted from a popcount/lowest-set-bit view of the truth tables.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic [7:0] ex = 8'h00;
    logic [7:0] dut_fn = 8'h00;
    int         sel = 1;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [2:0] dut_in1, dut_in0, ff1, ff0, m_dut_in, m_ff;
    logic       busy1, busy0, done1, done0, pass1, pass0, ffv1, ffv0;
    logic [3:0] err1, err0, m_err;
    logic       m_busy, m_done, m_pass, m_ffv;
    logic       dut_y1, dut_y0;

    always #5 clk = ~clk;

    assign dut_y1 = dut_fn[dut_in1];
    assign dut_y0 = dut_fn[dut_in0];

    truth_table_checker #(.N_IN(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .start(st && (sel == 1)), .expected(ex),
        .dut_in(dut_in1), .dut_y(dut_y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1)
    );

    truth_table_checker #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk(clk), .reset_n(rst_n), .start(st && (sel == 0)), .expected(ex),
        .dut_in(dut_in0), .dut_y(dut_y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(ff0), .first_fail_valid(ffv0)
    );

    always_comb begin
        if (sel == 1) begin
            m_dut_in = dut_in1; m_ff = ff1; m_busy = busy1; m_done = done1;
            m_pass = pass1; m_ffv = ffv1; m_err = err1;
        end else begin
            m_dut_in = dut_in0; m_ff = ff0; m_busy = busy0; m_done = done0;
            m_pass = pass0; m_ffv = ffv0; m_err = err0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sillyfunction: y = ~b&~c | a&~b, vector index = {a,b,c}
    function automatic logic [7:0] silly_table();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) begin
            logic a, b, c;
            {a, b, c} = 3'(v);
            t[v] = (~b & ~c) | (a & ~b);
        end
        return t;
    endfunction

    task automatic check_results(input string tag, input logic [7:0] tbl);
        int         errs = 0;
        logic [2:0] ff = 3'd0;
        bit         ffv = 1'b0;
        for (int v = 0; v < 8; v++) begin
            if (tbl[v] != dut_fn[v]) begin
                errs++;
                if (!ffv) begin
                    ff = 3'(v);
                    ffv = 1'b1;
                end
            end
        end
        check({tag, "_err"}, 32'(m_err), 32'(errs));
        check({tag, "_ff"}, 32'(m_ff), 32'(ff));
        check({tag, "_ffv"}, 32'(m_ffv), 32'(ffv));
        check({tag, "_pass"}, 32'(m_pass), 32'(errs == 0));
    endtask

    // Runs from the cycle after an accept until done; returns the cycle count at done.
    task automatic run_to_done(input int period, input int pulse_cyc, input int chg_cyc,
                               input bit hold, input logic [7:0] tbl, output int c);
        c = 1;
        while (!m_done && c < 8 * period + 6) begin
            if (c <= 8 * period) begin
                check("dut_in_seq", 32'(m_dut_in), 32'((c - 1) / period));
                check("busy_run", 32'(m_busy), 32'd1);
            end
            st = hold || (c == pulse_cyc);
            if (c == chg_cyc) ex = ~tbl;
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic sweep(input int inst, input logic [7:0] tbl, input string tag,
                         input int pulse_cyc, input int chg_cyc, input bit hold);
        int period = inst + 1;
        int c;
        sel = inst;
        ex = tbl;
        st = 1'b1;
        @(posedge clk); #1;
        st = hold;
        check({tag, "_busy_acc"}, 32'(m_busy), 32'd1);
        check({tag, "_cleared"}, {m_err, m_ffv, m_pass}, 32'd0);
        run_to_done(period, pulse_cyc, chg_cyc, hold, tbl, c);
        check({tag, "_done_lat"}, 32'(c), 32'(8 * period + 1));
        check({tag, "_done"}, 32'(m_done), 32'd1);
        check({tag, "_busy_done"}, 32'(m_busy), 32'd0);
        check({tag, "_dut_in0"}, 32'(m_dut_in), 32'd0);
        check_results(tag, tbl);
        ex = tbl;
        @(posedge clk); #1;
        st = 1'b0;
        if (hold) begin
            check({tag, "_b2b_busy"}, 32'(m_busy), 32'd1);
            check({tag, "_b2b_clr"}, {m_done, m_err, m_ffv, m_pass, m_dut_in}, 32'd0);
            run_to_done(period, -1, -1, 1'b0, tbl, c);
            check({tag, "_b2b_lat"}, 32'(c), 32'(8 * period + 1));
            check_results({tag, "_b2b"}, tbl);
            @(posedge clk); #1;
        end
        check({tag, "_idle"}, {m_done, m_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] silly;
        int         c;
        silly = silly_table();
        check("silly_tbl", 32'(silly), 32'h31);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            check("rst_out", {m_dut_in, m_busy, m_done, m_pass, m_err, m_ff, m_ffv}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        dut_fn = silly;
        sweep(1, 8'h31, "good", -1, -1, 1'b0);
        sweep(1, 8'h33, "bit1", -1, -1, 1'b0);
        dut_fn = 8'h00;
        sweep(1, 8'h31, "tie0", -1, -1, 1'b0);
        dut_fn = ~silly;
        sweep(1, 8'h31, "inv", -1, -1, 1'b0);
        dut_fn = silly;
        sweep(1, 8'h31, "pulse3", 7, -1, 1'b0);
        sweep(1, 8'h33, "hold", -1, -1, 1'b1);
        sweep(1, 8'h31, "chgexp", -1, 5, 1'b0);
        sweep(0, 8'h31, "s0good", -1, -1, 1'b0);
        dut_fn = ~silly;
        sweep(0, 8'h31, "s0inv", -1, -1, 1'b0);

        // Mid-sweep reset with a failing DUT so partial results are non-zero beforehand
        dut_fn = 8'h00;
        sel = 1;
        ex = 8'h31;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        c = 0;
        while (m_dut_in != 3'd4 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_v4", 32'(m_dut_in), 32'd4);
        check("pre_rst_err", 32'(m_err != 0), 32'd1);
        rst_n = 1'b0;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        check("midrst_out", {m_dut_in, m_busy, m_done, m_pass, m_err, m_ff, m_ffv}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_idle", {m_busy, m_done}, 32'd0);
        dut_fn = silly;
        sweep(1, 8'h31, "postrst", -1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            dut_fn = 8'($urandom);
            sweep(i % 2, 8'($urandom), $sformatf("rnd%0d", i), -1, -1, 1'b0);
        end
        dut_fn = 8'($urandom);
        sweep(1, dut_fn, "rndmatch", -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
